pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXP_VECTOR, 32'h0000_0100, trap handler entry address.
REQ-002 Parameter CNT_W, 16, stall-cycle counter width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low; clock clk.
REQ-005 ld_hazard  in  1  load-use hazard from decoder.
REQ-006 br_taken  in  1  branch/jump taken, resolved in ID.
REQ-007 br_addr  in  32  branch target.
REQ-008 if_busy  in  1  instruction fetch not complete this cycle.
REQ-009 mem_busy  in  1  data memory access not complete this cycle.
REQ-010 exp_req  in  1  exception raised by instruction in EX.
REQ-011 exp_pc  in  32  PC of the excepting instruction.
REQ-012 eret_req  in  1  return-from-exception in EX.
REQ-013 pc_stall  out  1  hold PC register.
REQ-014 if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold IF/ID, ID/EX, EX/MEM, MEM/WB registers.
REQ-015 if_flush, id_flush, ex_flush, mem_flush  out  1 each  load bubble (en=0) into the same registers.
REQ-016 redirect  out  1  PC loads new_pc this cycle.
REQ-017 new_pc  out  32  redirect target.
REQ-018 epc  out  32  registered exception PC.
REQ-019 stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1.

Function
REQ-020 States RUN, MEM_WAIT, TRAP (registered); all stall/flush/redirect/new_pc outputs combinational from state and inputs, 0 unless stated.
REQ-021 Registered pending redirect pend_v/pend_addr holds a branch target blocked by if_busy.
REQ-022 RUN priority, highest first: mem_busy, exp_req, eret_req, ld_hazard, br_taken, pend_v/if_busy.
REQ-023 RUN, mem_busy=1: pc/if/id/ex/mem_stall=1, mem_flush=1, no redirect, no epc update; next MEM_WAIT.
REQ-024 MEM_WAIT: same outputs while mem_busy=1; when mem_busy=0 all outputs 0 this cycle, next RUN; exp_req/eret_req/ld_hazard/br_taken ignored in MEM_WAIT.
REQ-025 RUN, exp_req=1: if/id/ex_flush=1, pc_stall=1, epc<=exp_pc, pend_v<=0; next TRAP.
REQ-026 TRAP (exactly 1 cycle): redirect=1, new_pc=EXP_VECTOR, if_flush=1, all other inputs ignored; next RUN.
REQ-027 RUN, eret_req=1: redirect=1, new_pc=epc, if_flush=1, id_flush=1, pend_v<=0.
REQ-028 RUN, ld_hazard=1: pc_stall=1, if_stall=1, id_flush=1; br_taken same cycle ignored, no redirect, pend unchanged.
REQ-029 RUN, br_taken=1, if_busy=0: redirect=1, new_pc=br_addr, if_flush=1.
REQ-030 RUN, br_taken=1, if_busy=1: pc_stall=1, if_flush=1, pend_v<=1, pend_addr<=br_addr.
REQ-031 RUN, pend_v=1 (no higher event): if_busy=1 -> pc_stall=1, if_flush=1; if_busy=0 -> redirect=1, new_pc=pend_addr, if_flush=1, pend_v<=0.
REQ-032 RUN, if_busy=1 alone: pc_stall=1, if_flush=1.
REQ-033 stall_cnt increments by 1 each cycle pc_stall=1; holds at all-ones.

Reset
REQ-034 reset=0 at rising edge: state<=RUN, pend_v<=0, pend_addr<=0, epc<=0, stall_cnt<=0, from any state including TRAP/MEM_WAIT.
REQ-035 During reset=0 all stall/flush/redirect outputs 0, new_pc=0.

Verification
REQ-036 ld_hazard=1 and br_taken=1, br_addr=32'h40, one cycle -> pc_stall=if_stall=id_flush=1, redirect=0, stall_cnt=1.
REQ-037 br_taken=1, br_addr=32'h80, if_busy=1 two cycles then 0 -> pc_stall=1 two cycles, then redirect=1, new_pc=32'h80, pend_v cleared.
REQ-038 mem_busy=1 three cycles with exp_req=1, exp_pc=32'h24 throughout -> all stalls 3 cycles, epc unchanged; then flush if/id/ex, epc=32'h24, next cycle redirect new_pc=32'h100.
REQ-039 After REQ-038, eret_req=1 -> redirect=1, new_pc=32'h24, if_flush=id_flush=1.
REQ-040 reset=0 during TRAP -> next cycle state RUN, redirect=0, epc=0, stall_cnt=0.
REQ-041 CNT_W=4, pc_stall=1 for 20 cycles -> stall_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller for a 5-stage in-order core: load-use,
// branch redirect (with a deferred target while fetch is busy), memory wait, trap entry/return.
module pipe_ctrl #(
    parameter logic [31:0] EXP_VECTOR = 32'h0000_0100,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_hazard,
    input  logic             br_taken,
    input  logic [31:0]      br_addr,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             exp_req,
    input  logic [31:0]      exp_pc,
    input  logic             eret_req,
    output logic             pc_stall,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             redirect,
    output logic [31:0]      new_pc,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_TRAP     = 2'd2;

    logic [1:0]  state, state_nxt;
    logic        pend_v, pend_v_nxt;
    logic [31:0] pend_addr, pend_addr_nxt;
    logic [31:0] epc_nxt;

    always_comb begin
        pc_stall      = 1'b0;
        if_stall      = 1'b0;
        id_stall      = 1'b0;
        ex_stall      = 1'b0;
        mem_stall     = 1'b0;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        ex_flush      = 1'b0;
        mem_flush     = 1'b0;
        redirect      = 1'b0;
        new_pc        = 32'h0;
        state_nxt     = state;
        pend_v_nxt    = pend_v;
        pend_addr_nxt = pend_addr;
        epc_nxt       = epc;

        case (state)
            S_RUN: begin
                if (mem_busy) begin
                    {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = 5'b11111;
                    mem_flush = 1'b1;
                    state_nxt = S_MEM_WAIT;
                end else if (exp_req) begin
                    pc_stall   = 1'b1;
                    {if_flush, id_flush, ex_flush} = 3'b111;
                    epc_nxt    = exp_pc;
                    pend_v_nxt = 1'b0;
                    state_nxt  = S_TRAP;
                end else if (eret_req) begin
                    redirect   = 1'b1;
                    new_pc     = epc;
                    if_flush   = 1'b1;
                    id_flush   = 1'b1;
                    pend_v_nxt = 1'b0;
                end else if (ld_hazard) begin
                    pc_stall = 1'b1;
                    if_stall = 1'b1;
                    id_flush = 1'b1;
                end else if (br_taken) begin
                    if_flush = 1'b1;
                    if (if_busy) begin
                        // fetch still owns the PC: park the target until it frees up
                        pc_stall      = 1'b1;
                        pend_v_nxt    = 1'b1;
                        pend_addr_nxt = br_addr;
                    end else begin
                        // a fresh taken branch supersedes any older parked target
                        redirect   = 1'b1;
                        new_pc     = br_addr;
                        pend_v_nxt = 1'b0;
                    end
                end else if (pend_v) begin
                    if_flush = 1'b1;
                    if (if_busy) begin
                        pc_stall = 1'b1;
                    end else begin
                        redirect   = 1'b1;
                        new_pc     = pend_addr;
                        pend_v_nxt = 1'b0;
                    end
                end else if (if_busy) begin
                    pc_stall = 1'b1;
                    if_flush = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_busy) begin
                    {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = 5'b11111;
                    mem_flush = 1'b1;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_TRAP: begin
                redirect  = 1'b1;
                new_pc    = EXP_VECTOR;
                if_flush  = 1'b1;
                state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase

        // outputs are quiet while reset is held, whatever the stale state says
        if (!reset) begin
            {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = 5'b0;
            {if_flush, id_flush, ex_flush, mem_flush}           = 4'b0;
            redirect = 1'b0;
            new_pc   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RUN;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
            epc       <= 32'h0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pend_v    <= pend_v_nxt;
            pend_addr <= pend_addr_nxt;
            epc       <= epc_nxt;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal checks, then random traffic
// compared every cycle against a rule-level model (two DUTs: CNT_W=16 and CNT_W=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_hazard, br_taken, if_busy, mem_busy, exp_req, eret_req;
    logic [31:0] br_addr, exp_pc;

    logic        pc_stall, if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush, redirect;
    logic [31:0] new_pc, epc;
    logic [15:0] stall_cnt;

    logic        pc_stall4, if_stall4, id_stall4, ex_stall4, mem_stall4;
    logic        if_flush4, id_flush4, ex_flush4, mem_flush4, redirect4;
    logic [31:0] new_pc4, epc4;
    logic [3:0]  stall_cnt4;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXP_VECTOR(32'h0000_0100), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .ld_hazard(ld_hazard), .br_taken(br_taken),
        .br_addr(br_addr), .if_busy(if_busy), .mem_busy(mem_busy), .exp_req(exp_req),
        .exp_pc(exp_pc), .eret_req(eret_req), .pc_stall(pc_stall), .if_stall(if_stall),
        .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
        .mem_flush(mem_flush), .redirect(redirect), .new_pc(new_pc), .epc(epc),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.EXP_VECTOR(32'h0000_0100), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .ld_hazard(ld_hazard), .br_taken(br_taken),
        .br_addr(br_addr), .if_busy(if_busy), .mem_busy(mem_busy), .exp_req(exp_req),
        .exp_pc(exp_pc), .eret_req(eret_req), .pc_stall(pc_stall4), .if_stall(if_stall4),
        .id_stall(id_stall4), .ex_stall(ex_stall4), .mem_stall(mem_stall4),
        .if_flush(if_flush4), .id_flush(id_flush4), .ex_flush(ex_flush4),
        .mem_flush(mem_flush4), .redirect(redirect4), .new_pc(new_pc4), .epc(epc4),
        .stall_cnt(stall_cnt4)
    );

    // output vector order: pc,if,id,ex,mem stall | if,id,ex,mem flush | redirect
    localparam logic [9:0] O_PC   = 10'b10000_0000_0;
    localparam logic [9:0] O_IFS  = 10'b01000_0000_0;
    localparam logic [9:0] O_ALLS = 10'b11111_0000_0;
    localparam logic [9:0] O_IFF  = 10'b00000_1000_0;
    localparam logic [9:0] O_IDF  = 10'b00000_0100_0;
    localparam logic [9:0] O_EXF  = 10'b00000_0010_0;
    localparam logic [9:0] O_MEMF = 10'b00000_0001_0;
    localparam logic [9:0] O_RED  = 10'b00000_0000_1;

    // model: mode 0 = running, 1 = waiting on memory, 2 = trap redirect cycle
    int          m_mode, n_mode;
    bit          m_pv, n_pv, m_valid = 1'b0;
    logic [31:0] m_pa, n_pa, m_ep, n_ep;
    int          m_c16, n_c16, m_c4, n_c4;
    logic [9:0]  e_vec;
    logic [31:0] e_pc;

    function automatic logic [9:0] dut_vec(input bit four);
        if (four)
            return {pc_stall4, if_stall4, id_stall4, ex_stall4, mem_stall4,
                    if_flush4, id_flush4, ex_flush4, mem_flush4, redirect4};
        return {pc_stall, if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush, redirect};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        e_vec = '0; e_pc = '0;
        n_mode = m_mode; n_pv = m_pv; n_pa = m_pa; n_ep = m_ep;
        if (!reset) begin
            n_mode = 0; n_pv = 0; n_pa = '0; n_ep = '0;
        end else if (m_mode == 2) begin
            e_vec = O_RED | O_IFF; e_pc = 32'h100; n_mode = 0;
        end else if (m_mode == 1 || mem_busy) begin
            if (mem_busy) begin e_vec = O_ALLS | O_MEMF; n_mode = 1; end
            else n_mode = 0;
        end else if (exp_req) begin
            e_vec = O_PC | O_IFF | O_IDF | O_EXF; n_ep = exp_pc; n_pv = 0; n_mode = 2;
        end else if (eret_req) begin
            e_vec = O_RED | O_IFF | O_IDF; e_pc = m_ep; n_pv = 0;
        end else if (ld_hazard) begin
            e_vec = O_PC | O_IFS | O_IDF;
        end else if (br_taken && if_busy) begin
            e_vec = O_PC | O_IFF; n_pv = 1; n_pa = br_addr;
        end else if (br_taken) begin
            e_vec = O_RED | O_IFF; e_pc = br_addr; n_pv = 0;
        end else if (m_pv && !if_busy) begin
            e_vec = O_RED | O_IFF; e_pc = m_pa; n_pv = 0;
        end else if (m_pv || if_busy) begin
            e_vec = O_PC | O_IFF;
        end
        if (!reset) begin n_c16 = 0; n_c4 = 0; end
        else begin
            n_c16 = (e_vec[9] && m_c16 < 65535) ? m_c16 + 1 : m_c16;
            n_c4  = (e_vec[9] && m_c4 < 15) ? m_c4 + 1 : m_c4;
        end
        cmp("outs16", {22'h0, dut_vec(1'b0)}, {22'h0, e_vec});
        cmp("outs4", {22'h0, dut_vec(1'b1)}, {22'h0, e_vec});
        cmp("new_pc", new_pc, e_pc);
        if (m_valid) begin
            cmp("epc", epc, m_ep);
            cmp("stall_cnt16", {16'h0, stall_cnt}, m_c16);
            cmp("stall_cnt4", {28'h0, stall_cnt4}, m_c4);
        end
    end

    always @(posedge clk) begin
        m_mode = n_mode; m_pv = n_pv; m_pa = n_pa; m_ep = n_ep;
        m_c16 = n_c16; m_c4 = n_c4;
        if (!reset) m_valid = 1'b1;
    end

    task automatic idle();
        ld_hazard = 0; br_taken = 0; if_busy = 0; mem_busy = 0;
        exp_req = 0; eret_req = 0; br_addr = '0; exp_pc = '0;
    endtask

    // advance to just after the next rising edge, where inputs are driven
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 0;
        cyc(2);
        cmp("reset_quiet", {22'h0, dut_vec(1'b0)}, 32'h0);
        reset = 1;
        #2 cmp("reset_cnt", {16'h0, stall_cnt}, 32'h0);
        cmp("reset_epc", epc, 32'h0);

        // load-use hazard wins over a same-cycle branch
        cyc(1);
        ld_hazard = 1; br_taken = 1; br_addr = 32'h40;
        #2 cmp("ld_vs_br", {22'h0, dut_vec(1'b0)}, {22'h0, 10'b11000_0100_0});
        cyc(1); idle();
        #2 cmp("ld_cnt", {16'h0, stall_cnt}, 32'd1);

        // branch blocked by busy fetch, delivered once fetch frees
        cyc(1); br_taken = 1; br_addr = 32'h80; if_busy = 1;
        #2 cmp("br_busy1", {31'h0, pc_stall}, 32'd1);
        cyc(1); br_taken = 0;
        #2 cmp("br_busy2", {31'h0, pc_stall}, 32'd1);
        cyc(1); if_busy = 0;
        #2 cmp("br_pend_red", {31'h0, redirect}, 32'd1);
        cmp("br_pend_pc", new_pc, 32'h80);
        cyc(1);
        #2 cmp("br_pend_clr", {31'h0, redirect}, 32'd0);

        // exception held across a memory wait
        cyc(1); mem_busy = 1; exp_req = 1; exp_pc = 32'h24;
        for (int i = 0; i < 3; i++) begin
            #2 cmp("mem_wait", {22'h0, dut_vec(1'b0)}, {22'h0, O_ALLS | O_MEMF});
            cmp("mem_wait_epc", epc, 32'h0);
            cyc(1);
        end
        mem_busy = 0;
        #2 cmp("mem_release", {22'h0, dut_vec(1'b0)}, 32'h0);
        cyc(1);
        #2 cmp("exp_take", {22'h0, dut_vec(1'b0)}, {22'h0, O_PC | O_IFF | O_IDF | O_EXF});
        cyc(1); exp_req = 0;
        #2 cmp("trap_epc", epc, 32'h24);
        cmp("trap_pc", new_pc, 32'h100);
        cmp("trap_red", {31'h0, redirect}, 32'd1);
        cyc(1); eret_req = 1;
        #2 cmp("eret", {22'h0, dut_vec(1'b0)}, {22'h0, O_RED | O_IFF | O_IDF});
        cmp("eret_pc", new_pc, 32'h24);

        // reset landing during the trap cycle
        cyc(1); eret_req = 0; exp_req = 1; exp_pc = 32'h64;
        cyc(1); exp_req = 0; reset = 0;
        cyc(1); reset = 1;
        #2 cmp("trap_rst_red", {31'h0, redirect}, 32'd0);
        cmp("trap_rst_epc", epc, 32'h0);
        cmp("trap_rst_cnt", {16'h0, stall_cnt}, 32'd0);

        // narrow counter saturates
        if_busy = 1;
        cyc(20); if_busy = 0;
        #2 cmp("sat4", {28'h0, stall_cnt4}, 32'hF);
        cmp("cnt16_20", {16'h0, stall_cnt}, 32'd20);

        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            reset     = ($urandom_range(0, 59) != 0);
            mem_busy  = ($urandom_range(0, 99) < 12);
            exp_req   = ($urandom_range(0, 99) < 8);
            eret_req  = ($urandom_range(0, 99) < 10);
            ld_hazard = ($urandom_range(0, 99) < 20);
            br_taken  = ($urandom_range(0, 99) < 25);
            if_busy   = ($urandom_range(0, 99) < 35);
            br_addr   = $urandom & 32'hFFFF_FFFC;
            exp_pc    = $urandom & 32'hFFFF_FFFC;
        end
        cyc(1); idle(); reset = 1;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
